// File: rtl/key_entry.sv
// Hex keypad entry buffer: builds a number digit by digit, with backspace, clear and enter (commit).
// Latency 1 cycle from the strobe rising edge; no backpressure, each press is acted on once or rejected with err.
module key_entry #(
   parameter int NDIG = 8,
   localparam int CW = $clog2(NDIG + 1)
) (
   input  logic              hz100,
   input  logic              reset,
   input  logic [4:0]        keycode,
   input  logic              strobe,
   output logic [4*NDIG-1:0] entry,
   output logic [CW-1:0]     count,
   output logic [4*NDIG-1:0] value,
   output logic              done,
   output logic              err
);

   localparam int            W    = 4 * NDIG;
   localparam logic [CW-1:0] MAXC = CW'(NDIG);
   localparam logic [CW-1:0] ONE  = CW'(1);

   typedef enum logic [1:0] {IDLE, ENTRY, FULL} state_t;

   state_t          r_state;
   logic            r_strobe_d;
   logic [W-1:0]    r_entry;
   logic [W-1:0]    r_value;
   logic [CW-1:0]   r_count;
   logic            r_done;
   logic            r_err;

   logic            w_event;
   logic            w_is_digit;
   logic            w_is_bs;
   logic            w_is_clr;
   logic            w_is_ent;
   logic [W-1:0]    w_push;
   logic [W-1:0]    w_pop;

   assign w_event    = strobe & ~r_strobe_d;
   assign w_is_digit = ~keycode[4];
   assign w_is_bs    = (keycode == 5'd16);
   assign w_is_clr   = (keycode == 5'd17);
   assign w_is_ent   = (keycode == 5'd18);
   // Shift left drops nothing useful: FULL blocks digit pushes, so the top digit is always zero here.
   assign w_push     = (r_entry << 4) | W'(keycode[3:0]);
   assign w_pop      = r_entry >> 4;

   always_ff @(posedge hz100 or posedge reset) begin
      if (reset) begin
         r_state    <= IDLE;
         r_strobe_d <= 1'b0;
         r_entry    <= '0;
         r_value    <= '0;
         r_count    <= '0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_strobe_d <= strobe;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
         if (w_event) begin
            if (w_is_digit) begin
               if (r_state == FULL) begin
                  r_err <= 1'b1;
               end else begin
                  r_entry <= w_push;
                  r_count <= r_count + ONE;
                  r_state <= (r_count + ONE == MAXC) ? FULL : ENTRY;
               end
            end else if (w_is_bs) begin
               if (r_state == IDLE) begin
                  r_err <= 1'b1;
               end else begin
                  r_entry <= w_pop;
                  r_count <= r_count - ONE;
                  r_state <= (r_count == ONE) ? IDLE : ENTRY;
               end
            end else if (w_is_clr) begin
               r_entry <= '0;
               r_count <= '0;
               r_state <= IDLE;
            end else if (w_is_ent) begin
               r_value <= r_entry;
               r_done  <= 1'b1;
               r_entry <= '0;
               r_count <= '0;
               r_state <= IDLE;
            end
         end
      end
   end

   assign entry = r_entry;
   assign count = r_count;
   assign value = r_value;
   assign done  = r_done;
   assign err   = r_err;

endmodule

// File: tb/tb_key_entry.sv
// Bench for key_entry: directed scenarios plus random key traffic against a digit-queue reference model.
module tb_key_entry;

   localparam int NDIG = 8;

   logic        hz100;
   logic        reset;
   logic [4:0]  keycode;
   logic        strobe;
   logic [31:0] entry;
   logic [3:0]  count;
   logic [31:0] value;
   logic        done;
   logic        err;

   int checks = 0;
   int errors = 0;

   // Reference model: the typed number is a list of digits, oldest first.
   logic [3:0]  q[$];
   logic [31:0] m_value;
   logic        m_done;
   logic        m_err;
   logic        m_sd;

   key_entry #(.NDIG(NDIG)) dut (
      .hz100   (hz100),
      .reset   (reset),
      .keycode (keycode),
      .strobe  (strobe),
      .entry   (entry),
      .count   (count),
      .value   (value),
      .done    (done),
      .err     (err)
   );

   initial hz100 = 1'b0;
   always #5 hz100 = ~hz100;

   function automatic logic [31:0] fold();
      logic [31:0] e;
      e = 32'h0;
      foreach (q[i]) e = (e << 4) | 32'(q[i]);
      return e;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag);
      chk({tag, ".entry"}, entry, fold());
      chk({tag, ".count"}, 32'(count), 32'(q.size()));
      chk({tag, ".value"}, value, m_value);
      chk({tag, ".done"}, 32'(done), 32'(m_done));
      chk({tag, ".err"}, 32'(err), 32'(m_err));
   endtask

   task automatic model_key(input logic [4:0] k);
      if (k < 5'd16) begin
         if (q.size() == NDIG) m_err = 1'b1;
         else q.push_back(k[3:0]);
      end else if (k == 5'd16) begin
         if (q.size() == 0) m_err = 1'b1;
         else q.delete(q.size() - 1);
      end else if (k == 5'd17) begin
         q.delete();
      end else if (k == 5'd18) begin
         m_value = fold();
         m_done  = 1'b1;
         q.delete();
      end
   endtask

   // Drive one cycle of inputs, advance the model, then check just after the edge.
   task automatic step(input logic s, input logic [4:0] k, input string tag);
      strobe  = s;
      keycode = k;
      m_done  = 1'b0;
      m_err   = 1'b0;
      if (s && !m_sd) model_key(k);
      m_sd = s;
      @(posedge hz100);
      #1;
      chk_all(tag);
   endtask

   task automatic press(input logic [4:0] k, input string tag);
      step(1'b1, k, tag);
      step(1'b0, k, {tag, ".rel"});
   endtask

   initial begin
      logic       s;
      logic [4:0] k;
      int         r;

      reset   = 1'b1;
      strobe  = 1'b0;
      keycode = 5'd0;
      q.delete();
      m_value = 32'h0;
      m_done  = 1'b0;
      m_err   = 1'b0;
      m_sd    = 1'b0;
      #12;
      chk_all("reset");
      reset = 1'b0;
      step(1'b0, 5'd0, "idle");

      // 1, 2: three digits then commit
      press(5'd1, "t1.d1");
      press(5'd2, "t1.d2");
      press(5'd3, "t1.d3");
      chk("t1.entry_const", entry, 32'h123);
      press(5'd18, "t2.ent");
      chk("t2.value_const", value, 32'h0000_0123);

      // 3: nine digits, the ninth is rejected
      for (int i = 1; i <= 9; i++) press(5'(i), "t3.dig");
      chk("t3.entry_const", entry, 32'h1234_5678);

      // 4: A, B, then backspace past empty
      press(5'd17, "t4.clr");
      press(5'd10, "t4.a");
      press(5'd11, "t4.b");
      press(5'd16, "t4.bs1");
      press(5'd16, "t4.bs2");
      press(5'd16, "t4.bs3");

      // 5: a long hold is one press; re-press after one low cycle
      for (int i = 0; i < 50; i++) step(1'b1, 5'd5, "t5.hold");
      step(1'b0, 5'd5, "t5.rel");
      step(1'b1, 5'd5, "t5.again");
      step(1'b0, 5'd5, "t5.rel2");
      chk("t5.count_const", 32'(count), 32'd2);

      // 6: reset asserted mid-press while strobe is high
      press(5'd17, "t6.clr");
      press(5'd4, "t6.d4");
      press(5'd2, "t6.d2");
      strobe  = 1'b1;
      keycode = 5'd7;
      #2;
      reset = 1'b1;
      q.delete();
      m_value = 32'h0;
      m_done  = 1'b0;
      m_err   = 1'b0;
      m_sd    = 1'b0;
      #1;
      chk_all("t6.reset_async");
      #1;
      reset = 1'b0;
      for (int i = 0; i < 5; i++) step(1'b1, 5'd7, "t6.post");
      chk("t6.count_const", 32'(count), 32'd1);
      step(1'b0, 5'd7, "t6.rel");

      // 7: enter when empty, then an ignored code
      press(5'd17, "t7.clr");
      press(5'd18, "t7.ent_empty");
      press(5'd19, "t7.k19");
      press(5'd0, "t7.zero1");
      press(5'd0, "t7.zero2");
      press(5'd31, "t7.k31");

      // random key traffic
      s = 1'b0;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 2) != 0) s = ~s;
         r = int'($urandom_range(0, 11));
         if (r < 6)       k = 5'($urandom_range(0, 15));
         else if (r < 8)  k = 5'd16;
         else if (r == 8) k = 5'd17;
         else if (r == 9) k = 5'd18;
         else             k = 5'($urandom_range(19, 31));
         step(s, k, "rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
